// File: rtl/tag_pkg.sv
// Shared types for the tag game flow controller: game states, move directions,
// mover identity and the LFSR-to-bot-direction mapping.
package tag_pkg;

  localparam int TIMER_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  typedef enum logic {
    WHO_PLAYER = 1'b0,
    WHO_BOT    = 1'b1
  } who_e;

  typedef struct packed {
    logic valid;
    dir_e dir;
  } bot_move_t;

  // rnd 7 is the "bot stands still" code, so the bot skips its move that frame.
  function automatic bot_move_t rnd_to_move(input logic [2:0] rnd);
    bot_move_t m;
    m.valid = 1'b1;
    m.dir   = DIR_LEFT;
    case (rnd)
      3'd0, 3'd4: m.dir = DIR_LEFT;
      3'd1:       m.dir = DIR_RIGHT;
      3'd2, 3'd6: m.dir = DIR_UP;
      3'd3, 3'd5: m.dir = DIR_DOWN;
      default:    m.valid = 1'b0;
    endcase
    return m;
  endfunction

  // btn is {down, up, left, right}; down has the highest priority.
  function automatic dir_e btn_to_dir(input logic [3:0] btn);
    dir_e d;
    if (btn[3])      d = DIR_DOWN;
    else if (btn[2]) d = DIR_UP;
    else if (btn[1]) d = DIR_LEFT;
    else             d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/tag_round_sequencer_frame_countdown.sv
// Loadable 16-bit frame down counter that stops at zero.
// Used for both the round timer and the catch-flash counter.
module frame_countdown
  import tag_pkg::*;
#(
  parameter logic [TIMER_W-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               tick,
  output logic [TIMER_W-1:0] count,
  output logic               zero
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/tag_round_sequencer.sv
// Game-flow controller for the VGA tag game: round FSM, one-deep move queue,
// player-then-bot move sequencing, catch scoring and position resets.
module tag_round_sequencer
  import tag_pkg::*;
#(
  parameter int ROUND_FRAMES = 1800,
  parameter int WIN_FRAMES   = 120,
  parameter int SCORE_W      = 8
) (
  input  logic               CLK100MHZ,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [3:0]         btn_edge,
  input  logic               start,
  input  logic               caught,
  input  logic [2:0]         rnd,
  output logic               mv_valid,
  output logic               mv_who,
  output logic [1:0]         mv_dir,
  output logic               pos_reset,
  output logic [1:0]         state,
  output logic [15:0]        timer,
  output logic [SCORE_W-1:0] score,
  output logic               flash
);

  localparam logic [TIMER_W-1:0] ROUND_LOAD = TIMER_W'(ROUND_FRAMES);
  localparam logic [TIMER_W-1:0] WIN_LOAD   = TIMER_W'(WIN_FRAMES);

  state_e             state_q, state_d;
  logic               pend_valid_q, pend_valid_d;
  dir_e               pend_dir_q, pend_dir_d;
  logic               bot_pend_q, bot_pend_d;
  logic               caught_armed_q, caught_armed_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               mv_valid_q, mv_valid_d;
  who_e               mv_who_q, mv_who_d;
  dir_e               mv_dir_q, mv_dir_d;
  logic               pos_reset_q, pos_reset_d;
  logic               flash_q, flash_d;

  logic               in_play, in_win;
  logic               fresh_start, play_start, catch_hit, round_end, win_done;
  logic               issue_player, issue_bot;
  logic [TIMER_W-1:0] timer_cnt, win_cnt;
  logic               timer_zero, win_zero;
  bot_move_t          bot_mv;

  assign in_play     = (state_q == ST_PLAY);
  assign in_win      = (state_q == ST_WIN);
  assign fresh_start = start && ((state_q == ST_IDLE) || (state_q == ST_OVER));
  assign play_start  = in_play && start;
  assign catch_hit   = in_play && caught && caught_armed_q && !start;
  assign round_end   = in_play && frame_tick && !start && !catch_hit &&
                       (timer_zero || (timer_cnt == TIMER_W'(1)));
  assign win_done    = in_win && (win_zero || (frame_tick && (win_cnt == TIMER_W'(1))));

  // The bot slot always follows the player slot, so a new player move waits
  // rather than colliding with an outstanding bot move.
  assign issue_player = in_play && frame_tick && pend_valid_q && !bot_pend_q &&
                        !start && !catch_hit && !round_end;
  assign issue_bot    = in_play && bot_pend_q && !start && !catch_hit;
  assign bot_mv       = rnd_to_move(rnd);

  frame_countdown #(.RESET_VAL(ROUND_LOAD)) u_round_timer (
    .clk      (CLK100MHZ),
    .rst_n    (rst_n),
    .load     (fresh_start || play_start),
    .load_val (ROUND_LOAD),
    .tick     (in_play && frame_tick && !start),
    .count    (timer_cnt),
    .zero     (timer_zero)
  );

  frame_countdown #(.RESET_VAL('0)) u_win_counter (
    .clk      (CLK100MHZ),
    .rst_n    (rst_n),
    .load     (catch_hit),
    .load_val (WIN_LOAD),
    .tick     (in_win && frame_tick),
    .count    (win_cnt),
    .zero     (win_zero)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_OVER: if (start) state_d = ST_PLAY;
      ST_PLAY: begin
        if (start)          state_d = ST_PLAY;
        else if (catch_hit) state_d = ST_WIN;
        else if (round_end) state_d = ST_OVER;
      end
      ST_WIN:  if (win_done) state_d = ST_PLAY;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mv_valid_d     = 1'b0;
    mv_who_d       = WHO_PLAYER;
    mv_dir_d       = DIR_LEFT;
    bot_pend_d     = 1'b0;
    pos_reset_d    = fresh_start || play_start || catch_hit;
    flash_d        = (state_d == ST_WIN);
    pend_valid_d   = pend_valid_q;
    pend_dir_d     = pend_dir_q;
    score_d        = score_q;
    caught_armed_d = caught_armed_q;

    if (issue_bot) begin
      mv_valid_d = bot_mv.valid;
      mv_who_d   = WHO_BOT;
      mv_dir_d   = bot_mv.dir;
    end
    if (issue_player) begin
      mv_valid_d = 1'b1;
      mv_who_d   = WHO_PLAYER;
      mv_dir_d   = pend_dir_q;
      bot_pend_d = 1'b1;
    end

    // A press arriving on the tick cycle lands after the old entry is consumed.
    if (!in_play || play_start || catch_hit || round_end) begin
      pend_valid_d = 1'b0;
    end else begin
      if (issue_player) pend_valid_d = 1'b0;
      if (!pend_valid_d && (btn_edge != 4'b0000)) begin
        pend_valid_d = 1'b1;
        pend_dir_d   = btn_to_dir(btn_edge);
      end
    end

    if (fresh_start || play_start) begin
      score_d = '0;
    end else if (catch_hit && (score_q != {SCORE_W{1'b1}})) begin
      score_d = score_q + 1'b1;
    end

    if (catch_hit || (play_start && caught)) begin
      caught_armed_d = 1'b0;
    end else if (!caught) begin
      caught_armed_d = 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      pend_valid_q   <= 1'b0;
      pend_dir_q     <= DIR_LEFT;
      bot_pend_q     <= 1'b0;
      caught_armed_q <= 1'b1;
      score_q        <= '0;
      mv_valid_q     <= 1'b0;
      mv_who_q       <= WHO_PLAYER;
      mv_dir_q       <= DIR_LEFT;
      pos_reset_q    <= 1'b0;
      flash_q        <= 1'b0;
    end else begin
      pend_valid_q   <= pend_valid_d;
      pend_dir_q     <= pend_dir_d;
      bot_pend_q     <= bot_pend_d;
      caught_armed_q <= caught_armed_d;
      score_q        <= score_d;
      mv_valid_q     <= mv_valid_d;
      mv_who_q       <= mv_who_d;
      mv_dir_q       <= mv_dir_d;
      pos_reset_q    <= pos_reset_d;
      flash_q        <= flash_d;
    end
  end

  assign mv_valid  = mv_valid_q;
  assign mv_who    = mv_who_q;
  assign mv_dir    = mv_dir_q;
  assign pos_reset = pos_reset_q;
  assign state     = state_q;
  assign timer     = timer_cnt;
  assign score     = score_q;
  assign flash     = flash_q;

endmodule

// File: tb/tb_tag_round_sequencer.sv
// Directed bench for tag_round_sequencer: a full-size instance (1800/120) and a
// short-round instance (3/2) share one stimulus bus, steered by sel.
module tb_tag_round_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       frame_tick, start, caught;
  logic [3:0] btn_edge;
  logic [2:0] rnd;

  int n_checks = 0;
  int n_pass   = 0;

  logic       a_ft, a_start, a_caught, b_ft, b_start, b_caught;
  logic [3:0] a_btn, b_btn;

  logic        a_mv_valid, a_mv_who, a_pos_reset, a_flash;
  logic [1:0]  a_mv_dir, a_state;
  logic [15:0] a_timer;
  logic [7:0]  a_score;
  logic        b_mv_valid, b_mv_who, b_pos_reset, b_flash;
  logic [1:0]  b_mv_dir, b_state;
  logic [15:0] b_timer;
  logic [7:0]  b_score;

  logic        o_mv_valid, o_mv_who, o_pos_reset, o_flash;
  logic [1:0]  o_mv_dir, o_state;
  logic [15:0] o_timer;
  logic [7:0]  o_score;

  logic seen_mv, flash_low;

  always #5 clk = ~clk;

  assign a_ft     = frame_tick & ~sel;
  assign a_start  = start & ~sel;
  assign a_caught = caught & ~sel;
  assign a_btn    = btn_edge & {4{~sel}};
  assign b_ft     = frame_tick & sel;
  assign b_start  = start & sel;
  assign b_caught = caught & sel;
  assign b_btn    = btn_edge & {4{sel}};

  assign o_mv_valid  = sel ? b_mv_valid  : a_mv_valid;
  assign o_mv_who    = sel ? b_mv_who    : a_mv_who;
  assign o_mv_dir    = sel ? b_mv_dir    : a_mv_dir;
  assign o_pos_reset = sel ? b_pos_reset : a_pos_reset;
  assign o_state     = sel ? b_state     : a_state;
  assign o_timer     = sel ? b_timer     : a_timer;
  assign o_score     = sel ? b_score     : a_score;
  assign o_flash     = sel ? b_flash     : a_flash;

  tag_round_sequencer #(.ROUND_FRAMES(1800), .WIN_FRAMES(120), .SCORE_W(8)) dut_a (
    .CLK100MHZ (clk),
    .rst_n     (rst_n),
    .frame_tick(a_ft),
    .btn_edge  (a_btn),
    .start     (a_start),
    .caught    (a_caught),
    .rnd       (rnd),
    .mv_valid  (a_mv_valid),
    .mv_who    (a_mv_who),
    .mv_dir    (a_mv_dir),
    .pos_reset (a_pos_reset),
    .state     (a_state),
    .timer     (a_timer),
    .score     (a_score),
    .flash     (a_flash)
  );

  tag_round_sequencer #(.ROUND_FRAMES(3), .WIN_FRAMES(2), .SCORE_W(8)) dut_b (
    .CLK100MHZ (clk),
    .rst_n     (rst_n),
    .frame_tick(b_ft),
    .btn_edge  (b_btn),
    .start     (b_start),
    .caught    (b_caught),
    .rnd       (rnd),
    .mv_valid  (b_mv_valid),
    .mv_who    (b_mv_who),
    .mv_dir    (b_mv_dir),
    .pos_reset (b_pos_reset),
    .state     (b_state),
    .timer     (b_timer),
    .score     (b_score),
    .flash     (b_flash)
  );

  // Drive one cycle of inputs, let the edge land, then drop the pulse inputs.
  task automatic applyStimulus(input logic [3:0] b, input logic s, input logic ft,
                               input logic c, input logic [2:0] r);
    btn_edge   = b;
    start      = s;
    frame_tick = ft;
    caught     = c;
    rnd        = r;
    @(posedge clk);
    #1;
    btn_edge   = 4'b0000;
    start      = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    sel = 1'b0;
    rst_n = 1'b0;
    btn_edge = 4'b0000; start = 1'b0; frame_tick = 1'b0; caught = 1'b0; rnd = 3'd0;
    applyStimulus(4'b0000, 0, 0, 0, 3'd0);
    applyStimulus(4'b0000, 0, 0, 0, 3'd0);
    checkOutput("rst_state",     o_state, 0);
    checkOutput("rst_timer",     o_timer, 1800);
    checkOutput("rst_score",     o_score, 0);
    checkOutput("rst_flash",     o_flash, 0);
    checkOutput("rst_mv_valid",  o_mv_valid, 0);
    checkOutput("rst_mv_dir",    o_mv_dir, 0);
    checkOutput("rst_pos_reset", o_pos_reset, 0);
    rst_n = 1'b1;

    // Start from IDLE
    applyStimulus(4'b0000, 1, 0, 0, 3'd0);
    checkOutput("start_pos_reset", o_pos_reset, 1);
    checkOutput("start_state",     o_state, 1);
    checkOutput("start_timer",     o_timer, 1800);
    checkOutput("start_score",     o_score, 0);
    applyStimulus(4'b0000, 0, 0, 0, 3'd0);
    checkOutput("pos_reset_one_cycle", o_pos_reset, 0);

    // Press left, tick, bot direction from rnd=3 at T+1
    applyStimulus(4'b0010, 0, 0, 0, 3'd0);
    checkOutput("press_no_mv", o_mv_valid, 0);
    applyStimulus(4'b0000, 0, 1, 0, 3'd1);
    checkOutput("p1_valid", o_mv_valid, 1);
    checkOutput("p1_who",   o_mv_who, 0);
    checkOutput("p1_dir",   o_mv_dir, 0);
    checkOutput("p1_timer", o_timer, 1799);
    applyStimulus(4'b0000, 0, 0, 0, 3'd3);
    checkOutput("b1_valid", o_mv_valid, 1);
    checkOutput("b1_who",   o_mv_who, 1);
    checkOutput("b1_dir",   o_mv_dir, 3);
    applyStimulus(4'b0000, 0, 0, 0, 3'd0);
    checkOutput("b1_end", o_mv_valid, 0);

    // Up then right in one frame: only up; rnd=7 gives no bot move
    applyStimulus(4'b0100, 0, 0, 0, 3'd0);
    applyStimulus(4'b0001, 0, 0, 0, 3'd0);
    applyStimulus(4'b0000, 0, 1, 0, 3'd0);
    checkOutput("p2_valid", o_mv_valid, 1);
    checkOutput("p2_dir",   o_mv_dir, 2);
    applyStimulus(4'b0000, 0, 0, 0, 3'd7);
    checkOutput("b2_none", o_mv_valid, 0);
    applyStimulus(4'b0000, 0, 1, 0, 3'd0);
    checkOutput("dropped_press", o_mv_valid, 0);
    checkOutput("timer_1797", o_timer, 1797);

    // Press on the tick cycle is latched for the next frame
    applyStimulus(4'b1000, 0, 1, 0, 3'd0);
    checkOutput("tick_press_late", o_mv_valid, 0);
    applyStimulus(4'b0000, 0, 1, 0, 3'd0);
    checkOutput("p3_valid", o_mv_valid, 1);
    checkOutput("p3_dir",   o_mv_dir, 3);
    checkOutput("timer_1795", o_timer, 1795);
    applyStimulus(4'b0000, 0, 0, 0, 3'd7);

    // Catch with a pending press; WIN lasts exactly 120 ticks
    applyStimulus(4'b0010, 0, 0, 0, 3'd0);
    applyStimulus(4'b0000, 0, 0, 1, 3'd0);
    checkOutput("catch_score",     o_score, 1);
    checkOutput("catch_pos_reset", o_pos_reset, 1);
    checkOutput("catch_state",     o_state, 2);
    checkOutput("catch_flash",     o_flash, 1);
    seen_mv = 1'b0;
    flash_low = 1'b0;
    for (int i = 0; i < 119; i++) begin
      applyStimulus(4'b0100, 0, 1, 1, 3'd0);
      if (o_mv_valid !== 1'b0) seen_mv = 1'b1;
      if (o_flash !== 1'b1) flash_low = 1'b1;
      applyStimulus(4'b0001, 1, 0, 1, 3'd0);
      if (o_mv_valid !== 1'b0) seen_mv = 1'b1;
      if (o_flash !== 1'b1) flash_low = 1'b1;
    end
    checkOutput("win_no_mv",      seen_mv, 0);
    checkOutput("win_flash_held", flash_low, 0);
    checkOutput("win_score_held", o_score, 1);
    applyStimulus(4'b0000, 0, 1, 1, 3'd0);
    checkOutput("win_exit_flash", o_flash, 0);
    checkOutput("win_exit_state", o_state, 1);
    checkOutput("win_timer_frozen", o_timer, 1795);
    applyStimulus(4'b0000, 0, 0, 1, 3'd0);
    checkOutput("held_caught_no_rescore", o_score, 1);
    checkOutput("held_caught_state", o_state, 1);
    applyStimulus(4'b0000, 0, 1, 1, 3'd0);
    checkOutput("pending_cleared_by_catch", o_mv_valid, 0);
    checkOutput("timer_1794", o_timer, 1794);
    applyStimulus(4'b0000, 0, 0, 0, 3'd0);

    // Reset between T+1 and T+2
    applyStimulus(4'b0001, 0, 0, 0, 3'd0);
    applyStimulus(4'b0000, 0, 1, 0, 3'd0);
    checkOutput("p4_valid", o_mv_valid, 1);
    checkOutput("p4_dir",   o_mv_dir, 1);
    rst_n = 1'b0;
    applyStimulus(4'b0000, 0, 0, 0, 3'd3);
    checkOutput("midrst_mv_valid",  o_mv_valid, 0);
    checkOutput("midrst_state",     o_state, 0);
    checkOutput("midrst_timer",     o_timer, 1800);
    checkOutput("midrst_score",     o_score, 0);
    checkOutput("midrst_pos_reset", o_pos_reset, 0);
    rst_n = 1'b1;
    applyStimulus(4'b0000, 0, 0, 0, 3'd3);
    checkOutput("midrst_no_trailing", o_mv_valid, 0);

    // Short-round instance: expiry, OVER, caught on the expiry tick
    sel = 1'b1;
    applyStimulus(4'b0000, 1, 0, 0, 3'd0);
    checkOutput("b_start_state", o_state, 1);
    checkOutput("b_start_timer", o_timer, 3);
    applyStimulus(4'b0000, 0, 1, 0, 3'd0);
    checkOutput("b_timer_2", o_timer, 2);
    applyStimulus(4'b0000, 0, 1, 0, 3'd0);
    checkOutput("b_state_play", o_state, 1);
    applyStimulus(4'b0000, 0, 1, 0, 3'd0);
    checkOutput("b_over_state", o_state, 3);
    checkOutput("b_over_timer", o_timer, 0);
    applyStimulus(4'b0000, 0, 1, 0, 3'd0);
    checkOutput("b_over_timer_held", o_timer, 0);
    applyStimulus(4'b0000, 1, 0, 0, 3'd0);
    checkOutput("b_restart_state", o_state, 1);
    checkOutput("b_restart_timer", o_timer, 3);
    applyStimulus(4'b0000, 0, 1, 0, 3'd0);
    applyStimulus(4'b0000, 0, 1, 0, 3'd0);
    applyStimulus(4'b0000, 0, 1, 1, 3'd0);
    checkOutput("b_catch_expiry_state", o_state, 2);
    checkOutput("b_catch_expiry_timer", o_timer, 0);
    checkOutput("b_catch_expiry_score", o_score, 1);
    applyStimulus(4'b0000, 0, 1, 0, 3'd0);
    checkOutput("b_win_stay", o_state, 2);
    applyStimulus(4'b0000, 0, 1, 0, 3'd0);
    checkOutput("b_win_back", o_state, 1);
    applyStimulus(4'b0000, 0, 1, 0, 3'd0);
    checkOutput("b_late_over", o_state, 3);

    // Score saturation
    applyStimulus(4'b0000, 1, 0, 0, 3'd0);
    checkOutput("b_sat_start_score", o_score, 0);
    for (int i = 0; i < 255; i++) begin
      applyStimulus(4'b0000, 0, 0, 1, 3'd0);
      applyStimulus(4'b0000, 0, 1, 1, 3'd0);
      applyStimulus(4'b0000, 0, 1, 1, 3'd0);
      applyStimulus(4'b0000, 0, 0, 1, 3'd0);
      if (i == 0) checkOutput("b_first_catch_once", o_score, 1);
      applyStimulus(4'b0000, 0, 0, 0, 3'd0);
    end
    checkOutput("b_score_255", o_score, 255);
    checkOutput("b_play_after_loop", o_state, 1);
    applyStimulus(4'b0000, 0, 0, 1, 3'd0);
    checkOutput("b_score_saturated", o_score, 255);
    checkOutput("b_sat_state", o_state, 2);
    checkOutput("b_sat_pos_reset", o_pos_reset, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tag_round_sequencer.md
# tag_round_sequencer

Game-flow controller for the VGA tag game. Sits between the button edge detectors, the LFSR and the vga position registers, and owns all movement scheduling. Serialises one player move and one bot move per frame, enforces a per-round frame timer, counts catches, and issues position resets. The position registers only apply commands from this block.

## Interface

Parameters:
- ROUND_FRAMES, 1800: frames per round (30 s at 60 Hz).
- WIN_FRAMES, 120: frames the catch flash lasts.
- SCORE_W, 8: score width.

Ports:
- CLK100MHZ  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- frame_tick  in  1  one-cycle pulse at each frame start (V_count wrap).
- btn_edge  in  4  one-cycle press pulses {down,up,left,right}.
- start  in  1  one-cycle centre-button pulse.
- caught  in  1  level, player and bot squares coincide.
- rnd  in  3  LFSR value.
- mv_valid  out  1  one-cycle move command.
- mv_who  out  1  0 = player, 1 = bot.
- mv_dir  out  2  0 = left, 1 = right, 2 = up, 3 = down.
- pos_reset  out  1  one-cycle pulse, return both squares to start.
- state  out  2  0 IDLE, 1 PLAY, 2 WIN, 3 OVER.
- timer  out  16  frames remaining in round.
- score  out  SCORE_W  catches this game.
- flash  out  1  high throughout WIN.

## Operation

- Reset values: state IDLE, timer = ROUND_FRAMES, score 0, flash 0, mv_valid 0, mv_who 0, mv_dir 0, pos_reset 0, pending empty.
- IDLE: start -> pos_reset pulse, score 0, timer = ROUND_FRAMES, go to PLAY. All other inputs are ignored.
- PLAY, pending register (1 deep):
  - Captures btn_edge when empty.
  - Priority within one cycle: down > up > left > right.
  - While full, further presses are dropped.
- PLAY, frame_tick:
  - timer decrements.
  - If pending is full, run the move sequence and clear pending.
  - If timer was 1 (reaches 0), go to OVER; a pending move is discarded and no moves issue.
- Move sequence, starting from the frame_tick cycle T:
  - T+1: mv_valid, who = 0, dir = pending.
  - T+2: mv_valid, who = 1, dir from rnd sampled at T+1. rnd 0/4 -> left, 1 -> right, 2/6 -> up, 3/5 -> down, 7 -> no bot move.
- PLAY, caught high:
  - score += 1, saturating at all-ones.
  - pos_reset pulse, pending cleared, any not-yet-issued bot move aborted.
  - WIN counter = WIN_FRAMES, go to WIN.
- PLAY, start: pos_reset, timer reload, score 0, pending cleared, stay in PLAY.
- WIN:
  - flash = 1; each frame_tick decrements the WIN counter. At 0, go to PLAY with flash 0 and timer unchanged.
  - btn_edge, caught and start are ignored. timer is frozen.
- OVER: timer holds 0 and score holds. start behaves as in IDLE.

## Timing

- All outputs are registered; no combinational input-to-output path.
- At most two mv_valid pulses per frame, always player then bot on consecutive cycles.
- Simultaneous events in PLAY, same cycle:
  - caught and timer expiry: caught wins, go to WIN, timer left at 0. On return to PLAY, the next frame_tick goes to OVER.
  - start and caught: start wins, no score increment.
  - btn_edge and frame_tick: the tick is evaluated against the old pending; the new press is latched for the next frame.
- caught is level: re-entry to PLAY from WIN does not re-score until caught has been seen low for at least one cycle. Track this with a caught_armed flag, reset to 1.
- rst_n low mid-sequence: the next edge forces reset values; no trailing mv_valid.
- timer arithmetic is 16-bit unsigned and never decrements below 0.

## Structure

- Package tag_pkg: state encodings, direction codes, who codes, rnd-to-direction function.
- Sub-module frame_countdown:
  - Loadable 16-bit down counter with load, tick enable and zero flag.
  - Instantiated twice: round timer and WIN counter.
- Top level: FSM, pending register, move-sequence stage, score register.

## Test plan

- Reset, then start: pos_reset at +1, state = 1, timer = 1800, score = 0.
- PLAY, press left (btn_edge = 4'b0010), tick with rnd = 3 at T+1: mv (0, left) at T+1, mv (1, down) at T+2.
- Two presses in one frame (up, then right): only up issued. rnd = 7: no bot pulse.
- caught in PLAY: score 0 -> 1, pos_reset, flash high for exactly 120 ticks; buttons during WIN produce no mv_valid.
- ROUND_FRAMES = 3: three ticks -> state = 3, timer = 0. caught and expiry on the same cycle -> WIN, score incremented.
- Score at 255 plus catch: stays 255. rst_n low between T+1 and T+2: no bot pulse, all outputs at reset values.
